cmos_gate_driver: RTL and testbench



---
 rtl/cmos_gate_driver.sv | 137 +++++++++++++
 tb/tb_cmos_gate_driver.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/cmos_gate_driver.sv
// cmos_gate_driver: break-before-make gate-drive controller for a
// complementary CMOS output stage (PMOS pull-up, NMOS pull-down).
//
// Ports:
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   en            driver enable; 0 forces both devices off and clears a latched fault
//   drive_req     requested level: 1 = pull-up (PMOS on), 0 = pull-down (NMOS on)
//   fault         synchronous fault request; forces off and latches
//   pmos_gate     PMOS gate, active-low (0 = conducting)
//   nmos_gate     NMOS gate, active-high (1 = conducting)
//   dead_active   high while in the dead-time state
//   fault_latched sticky fault indicator
//   sw_count      count of entries into PU or PD, wraps modulo 2**CNT_W
module cmos_gate_driver #(
  parameter int unsigned DEAD_CYCLES = 3,
  parameter int unsigned DT_W        = 4,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             drive_req,
  input  logic             fault,
  output logic             pmos_gate,
  output logic             nmos_gate,
  output logic             dead_active,
  output logic             fault_latched,
  output logic [CNT_W-1:0] sw_count
);

  localparam logic [1:0] S_OFF  = 2'd0;
  localparam logic [1:0] S_PU   = 2'd1;
  localparam logic [1:0] S_DEAD = 2'd2;
  localparam logic [1:0] S_PD   = 2'd3;

  localparam logic [DT_W-1:0] DT_LOAD = DT_W'(DEAD_CYCLES);
  localparam logic [DT_W-1:0] DT_ONE  = DT_W'(1);

  logic [1:0]       r_state;
  logic [DT_W-1:0]  r_cnt;
  logic             r_pmos;
  logic             r_nmos;
  logic             r_dead;
  logic             r_flt;
  logic [CNT_W-1:0] r_sw;

  logic [1:0]       w_state_nxt;
  logic [DT_W-1:0]  w_cnt_nxt;
  logic             w_flt_nxt;
  logic             w_enter_on;

  // Next-state, dead counter and fault latch; fault beats en, en beats normal flow.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_flt_nxt   = r_flt;
    if (fault) begin
      w_state_nxt = S_OFF;
      w_cnt_nxt   = '0;
      w_flt_nxt   = 1'b1;
    end else if (!en) begin
      w_state_nxt = S_OFF;
      w_cnt_nxt   = '0;
      w_flt_nxt   = 1'b0;
    end else begin
      case (r_state)
        S_OFF: begin
          if (!r_flt) begin
            w_state_nxt = S_DEAD;
            w_cnt_nxt   = DT_LOAD;
          end
        end
        S_PU: begin
          if (!drive_req) begin
            w_state_nxt = S_DEAD;
            w_cnt_nxt   = DT_LOAD;
          end
        end
        S_PD: begin
          if (drive_req) begin
            w_state_nxt = S_DEAD;
            w_cnt_nxt   = DT_LOAD;
          end
        end
        S_DEAD: begin
          // Exit target is whatever drive_req is at the exit edge; a zero
          // count is treated like one so DEAD can never stall.
          if (r_cnt <= DT_ONE) begin
            w_state_nxt = drive_req ? S_PU : S_PD;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt - DT_ONE;
          end
        end
        default: begin
          w_state_nxt = S_OFF;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // On-states are only reachable from DEAD, so any change into PU/PD is an entry.
  assign w_enter_on = (w_state_nxt != r_state) &&
                      ((w_state_nxt == S_PU) || (w_state_nxt == S_PD));

  // State plus outputs decoded from the next state, so gates move with the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_OFF;
      r_cnt   <= '0;
      r_pmos  <= 1'b1;
      r_nmos  <= 1'b0;
      r_dead  <= 1'b0;
      r_flt   <= 1'b0;
      r_sw    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_pmos  <= (w_state_nxt != S_PU);
      r_nmos  <= (w_state_nxt == S_PD);
      r_dead  <= (w_state_nxt == S_DEAD);
      r_flt   <= w_flt_nxt;
      if (w_enter_on) begin
        r_sw <= r_sw + CNT_W'(1);
      end
    end
  end

  assign pmos_gate     = r_pmos;
  assign nmos_gate     = r_nmos;
  assign dead_active   = r_dead;
  assign fault_latched = r_flt;
  assign sw_count      = r_sw;

endmodule

// File: tb/tb_cmos_gate_driver.sv
// Directed bench for cmos_gate_driver. Two instances share stimulus: one with
// default widths, one with CNT_W=3 to exercise sw_count wrap.
module tb_cmos_gate_driver;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       drive_req;
  logic       fault;

  logic       pmos_gate, nmos_gate, dead_active, fault_latched;
  logic [7:0] sw_count;
  logic       pmos_gate3, nmos_gate3, dead_active3, fault_latched3;
  logic [2:0] sw_count3;

  int n_cmp = 0;
  int n_err = 0;
  int exp_sw = 0;

  cmos_gate_driver u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .drive_req(drive_req), .fault(fault),
    .pmos_gate(pmos_gate), .nmos_gate(nmos_gate), .dead_active(dead_active),
    .fault_latched(fault_latched), .sw_count(sw_count)
  );

  cmos_gate_driver #(.CNT_W(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .en(en), .drive_req(drive_req), .fault(fault),
    .pmos_gate(pmos_gate3), .nmos_gate(nmos_gate3), .dead_active(dead_active3),
    .fault_latched(fault_latched3), .sw_count(sw_count3)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected outputs: {pmos, nmos, dead, fault_latched} and switch count.
  task automatic exp_out(input string tag, input logic p, input logic n,
                         input logic d, input logic f);
    chk({tag, "/gates"}, {28'd0, pmos_gate, nmos_gate, dead_active, fault_latched},
        {28'd0, p, n, d, f});
    chk({tag, "/sw"}, {24'd0, sw_count}, 32'(exp_sw % 256));
    chk({tag, "/sw3"}, {29'd0, sw_count3}, 32'(exp_sw % 8));
  endtask

  // One clock, sample 1 time unit after the edge, and screen for shoot-through.
  task automatic step();
    @(posedge clk);
    #1;
    chk("no_shoot", {31'd0, (!pmos_gate && nmos_gate)}, 32'd0);
  endtask

  // Request a level, expect three dead cycles, then the on-state with count+1.
  task automatic transit(input string tag, input logic req);
    drive_req = req;
    for (int i = 0; i < 3; i++) begin
      step();
      exp_out({tag, "/dead"}, 1'b1, 1'b0, 1'b1, 1'b0);
    end
    step();
    exp_sw++;
    if (req) exp_out({tag, "/pu"}, 1'b0, 1'b0, 1'b0, 1'b0);
    else     exp_out({tag, "/pd"}, 1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; drive_req = 1'b0; fault = 1'b0;
    #12;
    exp_out("reset", 1'b1, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;

    // 1: idle in OFF with en low
    for (int i = 0; i < 10; i++) begin
      step();
      exp_out("idle", 1'b1, 1'b0, 1'b0, 1'b0);
    end

    // 2: OFF -> DEAD -> PU, then PU -> DEAD -> PD
    en = 1'b1;
    transit("t2_up", 1'b1);
    transit("t2_dn", 1'b0);

    // 3: back to PU, then a one-cycle drive_req glitch still costs a full dead time
    transit("t3_up", 1'b1);
    drive_req = 1'b0;
    step();
    exp_out("t3_glitch", 1'b1, 1'b0, 1'b1, 1'b0);
    drive_req = 1'b1;
    step();
    exp_out("t3_d2", 1'b1, 1'b0, 1'b1, 1'b0);
    step();
    exp_out("t3_d3", 1'b1, 1'b0, 1'b1, 1'b0);
    step();
    exp_sw++;
    exp_out("t3_pu", 1'b0, 1'b0, 1'b0, 1'b0);

    // 4: fault in PD latches and holds OFF until en is sampled low
    transit("t4_dn", 1'b0);
    fault = 1'b1;
    step();
    exp_out("t4_fault", 1'b1, 1'b0, 1'b0, 1'b1);
    fault = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      exp_out("t4_hold", 1'b1, 1'b0, 1'b0, 1'b1);
    end
    en = 1'b0;
    step();
    exp_out("t4_clear", 1'b1, 1'b0, 1'b0, 1'b0);
    en = 1'b1;
    transit("t4_resume", 1'b0);

    // fault while already OFF still latches
    en = 1'b0;
    step();
    exp_out("t4_off", 1'b1, 1'b0, 1'b0, 1'b0);
    fault = 1'b1;
    step();
    exp_out("t4_off_fault", 1'b1, 1'b0, 1'b0, 1'b1);
    fault = 1'b0;
    step();
    exp_out("t4_off_clr", 1'b1, 1'b0, 1'b0, 1'b0);
    en = 1'b1;
    transit("t4_restart", 1'b0);

    // 5: en dropped in the 2nd dead cycle abandons the dead time
    drive_req = 1'b1;
    step();
    exp_out("t5_d1", 1'b1, 1'b0, 1'b1, 1'b0);
    step();
    exp_out("t5_d2", 1'b1, 1'b0, 1'b1, 1'b0);
    en = 1'b0;
    step();
    exp_out("t5_off", 1'b1, 1'b0, 1'b0, 1'b0);
    en = 1'b1;
    transit("t5_up", 1'b1);

    // asynchronous reset mid-PU releases the PMOS without a clock edge
    #2;
    rst_n = 1'b0;
    #1;
    exp_sw = 0;
    exp_out("t5_async", 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    exp_out("t5_inrst", 1'b1, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    drive_req = 1'b0;

    // 6: nine switching events; the 3-bit count goes 7 -> 0 -> 1
    for (int k = 0; k < 9; k++) begin
      transit("t6_sw", (k % 2 == 0) ? 1'b1 : 1'b0);
    end
    chk("t6_wrap", {29'd0, sw_count3}, 32'd1);
    chk("t6_full", {24'd0, sw_count}, 32'd9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
